program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the pipelined CPU top level.
- Accepts a stream of 32-bit words over a valid/ready handshake and turns them into the CPU's instruction-memory write port (w_instruction, w_enable, w_adrs).
- Supports sparse programs through address-set words.
- After the last word plus a settle delay, asserts cpu_en to start execution; halt returns it to idle for a reload.

Parameters:
- ADRS_W, 11, instruction-memory address width (2048 words).
- BASE_ADRS, 0, write address loaded at each load start.
- START_DELAY, 2, idle cycles between the final memory write and cpu_en rising (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_req  input  1  pulse: begin a load session (honoured in IDLE only).
- halt  input  1  level: abort load / stop CPU, go to IDLE.
- s_valid  input  1  stream word valid.
- s_ready  output  1  stream word accepted when s_valid & s_ready.
- s_data  input  32  instruction word, or new address in [ADRS_W-1:0] when s_is_adrs=1.
- s_is_adrs  input  1  word is an address-set command, not an instruction.
- s_last  input  1  final word of the program.
- w_instruction  output  32  instruction to CPU memory.
- w_enable  output  1  memory write strobe.
- w_adrs  output  ADRS_W  memory write address.
- cpu_en  output  1  CPU run enable.
- word_count  output  ADRS_W+1  instructions written this session.
- err  output  1  sticky: write attempted past address 2^ADRS_W-1.

Behaviour:
- Reset (asynchronous, active-high), all outputs 0: state=IDLE, s_ready=0, w_enable=0, w_adrs=0, w_instruction=0, cpu_en=0, word_count=0, err=0, internal next_adrs=BASE_ADRS. Reset mid-load drops the session; nothing partial is retained.
- States: IDLE, LOAD, SETTLE, RUN.
- IDLE:
  - cpu_en=0.
  - load_req & !halt -> LOAD next cycle.
  - On this transition: next_adrs<=BASE_ADRS, word_count<=0, err<=0.
- LOAD:
  - s_ready = (state==LOAD) & !halt, combinational.
  - Accepted instruction word at edge N: w_enable=1, w_adrs=next_adrs, w_instruction=s_data, all registered and valid for exactly the cycle after edge N. next_adrs increments; word_count increments.
  - Accepted address word: next_adrs<=s_data[ADRS_W-1:0]. No write occurs and word_count is unchanged.
  - With no accepted word, w_enable=0 and w_adrs/w_instruction hold their values.
  - Accepted word with s_last=1 -> SETTLE. This applies to both instruction and address words.
  - Throughput: one word per cycle, no bubbles.
- Wrap-around:
  - Instruction accepted with next_adrs = 2^ADRS_W-1: write occurs, then next_adrs wraps to 0 and an internal wrapped flag is set.
  - Any further instruction accepted while wrapped is dropped: w_enable=0, err<=1, word_count unchanged.
  - An address word clears wrapped.
- SETTLE:
  - Counter loads START_DELAY on entry.
  - After START_DELAY cycles in SETTLE -> RUN.
  - cpu_en rises at edge (last-accept edge + START_DELAY + 1).
- RUN:
  - cpu_en=1 and s_ready=0.
  - load_req is ignored.
- halt:
  - From any state: next edge -> IDLE, cpu_en=0, w_enable=0.
  - halt wins over a simultaneous s_valid, since s_ready is already 0.
  - halt held high keeps the block in IDLE even with load_req present.

Test Plan:
- Reset, then load_req with stream 0xE0000C07, 0xE0460007 (s_last) -> w_adrs 0,1 with w_enable one cycle after each accept; cpu_en rises 3 edges after the last accept; word_count=2.
- Sparse program: addr-word 1, instr A, instr B, addr-word 4, instr C (s_last) -> writes at 1,2,4 only; word_count=3; no w_enable on address-word cycles.
- Back-to-back valid with random s_valid gaps -> every accepted word written exactly once, in order, at consecutive addresses.
- addr-word 2046, then three instructions -> writes at 2046, 2047, then the third is dropped; err=1; word_count=2.
- halt asserted with s_valid high in LOAD -> s_ready=0 same cycle, IDLE next edge, no write. Then load_req -> fresh session from BASE_ADRS with err cleared.
- Async reset asserted mid-SETTLE and mid-RUN -> cpu_en and all outputs 0 immediately, without waiting for a clock edge; state IDLE.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time instruction loader: turns a valid/ready word stream into CPU
// instruction-memory writes, then releases the CPU after a settle delay.
module program_loader #(
    parameter int unsigned ADRS_W      = 11,
    parameter int unsigned BASE_ADRS   = 0,
    parameter int unsigned START_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              halt,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_is_adrs,
    input  logic              s_last,
    output logic [31:0]       w_instruction,
    output logic              w_enable,
    output logic [ADRS_W-1:0] w_adrs,
    output logic              cpu_en,
    output logic [ADRS_W:0]   word_count,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADRS_W-1:0] next_adrs;
    logic              wrapped;
    logic [3:0]        settle_cnt;
    logic              accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        s_ready   = (state == LOAD) && !halt;
        accept    = s_valid && s_ready;
        cpu_en    = (state == RUN);
        state_nxt = state;
        if (halt) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (load_req) state_nxt = LOAD;
                LOAD:    if (accept && s_last) state_nxt = SETTLE;
                // Counter runs START_DELAY down to zero, so cpu_en rises
                // START_DELAY+1 edges after the final accept.
                SETTLE:  if (settle_cnt == 4'd0) state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_instruction <= '0;
            w_enable      <= 1'b0;
            w_adrs        <= '0;
            word_count    <= '0;
            err           <= 1'b0;
            next_adrs     <= ADRS_W'(BASE_ADRS);
            wrapped       <= 1'b0;
            settle_cnt    <= '0;
        end else begin
            w_enable <= 1'b0;
            if (state == IDLE && state_nxt == LOAD) begin
                next_adrs  <= ADRS_W'(BASE_ADRS);
                word_count <= '0;
                err        <= 1'b0;
                wrapped    <= 1'b0;
            end
            if (accept) begin
                if (s_is_adrs) begin
                    next_adrs <= s_data[ADRS_W-1:0];
                    wrapped   <= 1'b0;
                end else if (wrapped) begin
                    err <= 1'b1;
                end else begin
                    w_enable      <= 1'b1;
                    w_adrs        <= next_adrs;
                    w_instruction <= s_data;
                    next_adrs     <= next_adrs + ADRS_W'(1);
                    word_count    <= word_count + (ADRS_W+1)'(1);
                    if (next_adrs == '1) wrapped <= 1'b1;
                end
            end
            if (state != SETTLE && state_nxt == SETTLE)
                settle_cnt <= 4'(START_DELAY);
            else if (state == SETTLE && settle_cnt != 4'd0)
                settle_cnt <= settle_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with hand-computed expectations.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req, halt, s_valid, s_is_adrs, s_last;
    logic [31:0] s_data;
    logic        s_ready, w_enable, cpu_en, err;
    logic [31:0] w_instruction;
    logic [10:0] w_adrs;
    logic [11:0] word_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    program_loader #(.ADRS_W(11), .BASE_ADRS(0), .START_DELAY(2)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .halt(halt),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_is_adrs(s_is_adrs), .s_last(s_last),
        .w_instruction(w_instruction), .w_enable(w_enable), .w_adrs(w_adrs),
        .cpu_en(cpu_en), .word_count(word_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Presents one word; the DUT is in LOAD so it is accepted at the next edge.
    task automatic send(input logic [31:0] d, input logic is_adrs, input logic last);
        s_valid = 1'b1; s_data = d; s_is_adrs = is_adrs; s_last = last;
        check("s_ready_in_load", s_ready, 1);
        tick();
        s_valid = 1'b0; s_last = 1'b0; s_is_adrs = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_req = 0; halt = 0; s_valid = 0; s_is_adrs = 0; s_last = 0; s_data = '0;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_w_enable", w_enable, 0);
        check("rst_w_adrs", w_adrs, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_count", word_count, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("idle_s_ready", s_ready, 0);

        // Two-word program, cpu_en timing
        start_load();
        send(32'hE0000C07, 0, 0);
        check("t1_en0", w_enable, 1);
        check("t1_adrs0", w_adrs, 0);
        check("t1_instr0", w_instruction, 32'hE0000C07);
        send(32'hE0460007, 0, 1);
        check("t1_en1", w_enable, 1);
        check("t1_adrs1", w_adrs, 1);
        check("t1_instr1", w_instruction, 32'hE0460007);
        check("t1_count", word_count, 2);
        check("t1_cpu_en_edge0", cpu_en, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t1_cpu_en_rise", cpu_en, (k == 3));
            if (k == 1) begin
                check("t1_en_drop", w_enable, 0);
                check("t1_settle_ready", s_ready, 0);
            end
        end
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("run_ignores_load", cpu_en, 1);
        check("run_s_ready", s_ready, 0);
        do_halt();
        check("halt_run_cpu_en", cpu_en, 0);

        // Sparse program
        start_load();
        send(32'd1, 1, 0);
        check("sp_adrword_en", w_enable, 0);
        check("sp_adrword_count", word_count, 0);
        send(32'hAAAA0001, 0, 0);
        check("sp_a_adrs", w_adrs, 1);
        check("sp_a_en", w_enable, 1);
        send(32'hBBBB0002, 0, 0);
        check("sp_b_adrs", w_adrs, 2);
        send(32'd4, 1, 0);
        check("sp_adrword2_en", w_enable, 0);
        check("sp_hold_adrs", w_adrs, 2);
        send(32'hCCCC0003, 0, 1);
        check("sp_c_adrs", w_adrs, 4);
        check("sp_c_instr", w_instruction, 32'hCCCC0003);
        check("sp_count", word_count, 3);
        do_halt();

        // Random gaps between words
        start_load();
        for (int i = 0; i < 8; i++) begin
            int unsigned gap = $urandom_range(0, 2);
            for (int g = 0; g < int'(gap); g++) begin
                tick();
                check("gap_no_write", w_enable, 0);
            end
            send(32'h1000_0000 + i, 0, (i == 7));
            check("gap_en", w_enable, 1);
            check("gap_adrs", w_adrs, i);
            check("gap_instr", w_instruction, 32'h1000_0000 + i);
        end
        check("gap_count", word_count, 8);
        do_halt();

        // Address wrap-around
        start_load();
        send(32'd2046, 1, 0);
        send(32'h0000_07FE, 0, 0);
        check("wr_adrs_2046", w_adrs, 2046);
        send(32'h0000_07FF, 0, 0);
        check("wr_adrs_2047", w_adrs, 2047);
        check("wr_err_before", err, 0);
        send(32'h0000_0800, 0, 1);
        check("wr_dropped_en", w_enable, 0);
        check("wr_err", err, 1);
        check("wr_count", word_count, 2);
        do_halt();
        check("wr_err_sticky_idle", err, 1);

        // halt during LOAD, then fresh session
        start_load();
        check("fresh_err_cleared", err, 0);
        check("fresh_count", word_count, 0);
        send(32'hDEAD0000, 0, 0);
        check("h_first_adrs", w_adrs, 0);
        s_valid = 1'b1; s_data = 32'hDEAD0001; halt = 1'b1;
        #1;
        check("h_s_ready_same_cycle", s_ready, 0);
        tick();
        halt = 1'b0;
        check("h_no_write", w_enable, 0);
        check("h_idle_ready", s_ready, 0);
        s_valid = 1'b0;
        halt = 1'b1; load_req = 1'b1;
        tick();
        halt = 1'b0; load_req = 1'b0;
        check("h_held_idle", s_ready, 0);
        start_load();
        send(32'hBEEF0000, 0, 0);
        check("h_fresh_adrs", w_adrs, 0);
        check("h_fresh_count", word_count, 1);

        // Async reset mid-SETTLE
        send(32'hBEEF0001, 0, 1);
        check("ar_pre_en", w_enable, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_settle_en", w_enable, 0);
        check("ar_settle_adrs", w_adrs, 0);
        check("ar_settle_instr", w_instruction, 0);
        check("ar_settle_count", word_count, 0);
        #2 reset = 1'b0;
        tick();
        check("ar_settle_idle", cpu_en, 0);

        // Async reset mid-RUN
        start_load();
        send(32'h1234_5678, 0, 1);
        for (int k = 0; k < 3; k++) tick();
        check("ar_run_up", cpu_en, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_run_cpu_en", cpu_en, 0);
        check("ar_run_count", word_count, 0);
        #2 reset = 1'b0;
        tick();
        check("ar_run_idle_cpu", cpu_en, 0);
        check("ar_run_idle_ready", s_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
